// File: rtl/atm_keypad_frontend.sv
// atm_keypad_frontend
// User-side front end for the ATM core. Collects card-reader and keypad
// events, walks one session through IDLE/LANG/PSW/PSW_CHK/OP/VALUE/WAIT/
// MORE/EJECT and holds the request stable while the core is working.
// Optional feature macro: ATM_PSW_LOCKOUT_EN (three wrong passwords eject
// the card and lock that card_id out until reset; adds port card_locked).
module atm_keypad_frontend #(
  parameter int password_width = 4,
  parameter int balance_width  = 20,
  parameter int card_width     = 3,
  parameter int RESP_TIMEOUT   = 1024,
  parameter int PSW_CHK_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      card_insert,
  input  logic [card_width-1:0]     card_id,
  input  logic                      key_valid,
  input  logic [3:0]                key_code,
  input  logic                      op_done,
  input  logic                      error,
  input  logic                      wrong_psw,
  input  logic [balance_width-1:0]  updated_balance,
  output logic [card_width-1:0]     card_number,
  output logic [password_width-1:0] password_input,
  output logic                      language,
  output logic [1:0]                operation,
  output logic [balance_width-1:0]  value,
  output logic                      another_service,
  output logic                      req_valid,
  output logic [balance_width-1:0]  last_balance,
  output logic                      last_error,
  output logic                      eject,
`ifdef ATM_PSW_LOCKOUT_EN
  output logic                      card_locked,
`endif
  output logic                      busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LANG,
    S_PSW,
    S_PSW_CHK,
    S_OP,
    S_VALUE,
    S_WAIT,
    S_MORE,
    S_EJECT
  } state_t;

  // One counter serves both the password-check window and the response timeout.
  localparam int CNT_MAX = (RESP_TIMEOUT > PSW_CHK_CYCLES) ? RESP_TIMEOUT : PSW_CHK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CHK_LAST     = CNT_W'(PSW_CHK_CYCLES - 1);
  localparam logic [balance_width-1:0] VALUE_MAX = '1;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               psw_bad_reg;

  logic               key_digit;
  logic               key_enter;
  logic               key_cancel;
  logic               key_clear;
  logic               psw_bad_next;
  logic               insert_blocked;
  logic [balance_width+3:0] value_ext;
  logic [balance_width-1:0] value_next;

  assign key_digit  = key_valid && (key_code <= 4'd9);
  assign key_enter  = key_valid && (key_code == 4'hA);
  assign key_cancel = key_valid && (key_code == 4'hB);
  assign key_clear  = key_valid && (key_code == 4'hC);

  // Wrong-password evidence seen so far in the check window, including this cycle.
  assign psw_bad_next = psw_bad_reg | wrong_psw;

`ifdef ATM_PSW_LOCKOUT_EN
  logic [1:0]            fail_cnt_reg;
  logic [card_width-1:0] locked_card_reg;
  assign insert_blocked = card_locked && (card_id == locked_card_reg);
`else
  assign insert_blocked = 1'b0;
`endif

  // Decimal accumulate of the amount with saturation instead of wrap-around.
  always_comb begin
    value_ext  = ({4'b0000, value} * (balance_width + 4)'(10)) + (balance_width + 4)'(key_code);
    value_next = (value_ext > {4'b0000, VALUE_MAX}) ? VALUE_MAX : value_ext[balance_width-1:0];
  end

  // Session FSM; every output is a register written only here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= S_IDLE;
      cnt_reg         <= '0;
      psw_bad_reg     <= 1'b0;
      card_number     <= '0;
      password_input  <= '0;
      language        <= 1'b0;
      operation       <= '0;
      value           <= '0;
      another_service <= 1'b0;
      req_valid       <= 1'b0;
      last_balance    <= '0;
      last_error      <= 1'b0;
      eject           <= 1'b0;
      busy            <= 1'b0;
`ifdef ATM_PSW_LOCKOUT_EN
      fail_cnt_reg    <= '0;
      locked_card_reg <= '0;
      card_locked     <= 1'b0;
`endif
    end else begin
      eject           <= 1'b0;
      another_service <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (card_insert && !insert_blocked) begin
            card_number <= card_id;
            busy        <= 1'b1;
            state_reg   <= S_LANG;
          end
        end

        S_EJECT: begin
          card_number    <= '0;
          password_input <= '0;
          value          <= '0;
          operation      <= '0;
          language       <= 1'b0;
          cnt_reg        <= '0;
          psw_bad_reg    <= 1'b0;
          busy           <= 1'b0;
          state_reg      <= S_IDLE;
`ifdef ATM_PSW_LOCKOUT_EN
          fail_cnt_reg   <= '0;
`endif
        end

        S_WAIT: begin
          // Keypad is deliberately ignored here, CANCEL included.
          if (op_done) begin
            last_balance <= updated_balance;
            last_error   <= error;
            req_valid    <= 1'b0;
            cnt_reg      <= '0;
            state_reg    <= S_MORE;
          end else if (error) begin
            last_error   <= 1'b1;
            req_valid    <= 1'b0;
            cnt_reg      <= '0;
            state_reg    <= S_MORE;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            req_valid    <= 1'b0;
            cnt_reg      <= '0;
            eject        <= 1'b1;
            state_reg    <= S_EJECT;
          end else begin
            cnt_reg      <= cnt_reg + CNT_W'(1);
          end
        end

        default: begin
          if (key_cancel) begin
            cnt_reg   <= '0;
            eject     <= 1'b1;
            state_reg <= S_EJECT;
          end else begin
            case (state_reg)
              S_LANG: begin
                if (key_valid && (key_code <= 4'd1)) begin
                  language  <= key_code[0];
                  state_reg <= S_PSW;
                end
              end

              S_PSW: begin
                if (key_digit) begin
                  password_input <= password_width'(key_code);
                end else if (key_clear) begin
                  password_input <= '0;
                end else if (key_enter) begin
                  cnt_reg     <= '0;
                  psw_bad_reg <= 1'b0;
                  state_reg   <= S_PSW_CHK;
                end
              end

              S_PSW_CHK: begin
                // The whole window is observed before deciding.
                if (cnt_reg == CHK_LAST) begin
                  cnt_reg     <= '0;
                  psw_bad_reg <= 1'b0;
                  if (psw_bad_next) begin
`ifdef ATM_PSW_LOCKOUT_EN
                    if (fail_cnt_reg == 2'd2) begin
                      card_locked     <= 1'b1;
                      locked_card_reg <= card_number;
                      eject           <= 1'b1;
                      state_reg       <= S_EJECT;
                    end else begin
                      fail_cnt_reg   <= fail_cnt_reg + 2'd1;
                      password_input <= '0;
                      state_reg      <= S_PSW;
                    end
`else
                    password_input <= '0;
                    state_reg      <= S_PSW;
`endif
                  end else begin
`ifdef ATM_PSW_LOCKOUT_EN
                    fail_cnt_reg <= '0;
`endif
                    state_reg    <= S_OP;
                  end
                end else begin
                  cnt_reg     <= cnt_reg + CNT_W'(1);
                  psw_bad_reg <= psw_bad_next;
                end
              end

              S_OP: begin
                if (key_valid && (key_code >= 4'd1) && (key_code <= 4'd4)) begin
                  operation <= 2'(key_code - 4'd1);
                  value     <= '0;
                  state_reg <= S_VALUE;
                end
              end

              S_VALUE: begin
                if (key_digit) begin
                  value <= value_next;
                end else if (key_clear) begin
                  value <= '0;
                end else if (key_enter) begin
                  cnt_reg   <= '0;
                  req_valid <= 1'b1;
                  state_reg <= S_WAIT;
                end
              end

              S_MORE: begin
                if (key_valid && (key_code == 4'd1)) begin
                  another_service <= 1'b1;
                  state_reg       <= S_OP;
                end else if (key_valid && ((key_code == 4'd0) || (key_code == 4'hA))) begin
                  eject     <= 1'b1;
                  state_reg <= S_EJECT;
                end
              end

              default: begin
                state_reg <= S_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
